// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Shared definitions for the ALU issue stage:
//   - alu_op_e  : 4-bit ALU operation encodings driven on alu_ctrl
//   - OP_*      : RV32I major opcode constants (instr[6:0])
//   - F7_ALT    : funct7 value selecting SUB / SRA variants
//   - shift_funct7_ok : legality check of funct7 on immediate shifts
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // SLLI/SRLI need funct7 == 0; SRAI additionally allows F7_ALT.
    function automatic logic shift_funct7_ok(input logic [6:0] funct7, input logic is_right);
        logic ok;
        if (funct7 == 7'b0000000) begin
            ok = 1'b1;
        end else if (is_right && (funct7 == F7_ALT)) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Module: alu_decoder
// Purely combinational RV32I decode into an ALU operation and operand pair.
// Ports:
//   instr      in  32    instruction word
//   pc         in  XLEN  address of instr
//   rs1_data   in  XLEN  register-file read port 1
//   rs2_data   in  XLEN  register-file read port 2
//   a, b       out XLEN  ALU operands
//   alu_ctrl   out 4     ALU operation
//   rd         out 5     destination register field
//   reg_write  out 1     writeback enable (0 for branch/store/illegal/rd==0)
//   is_branch  out 1     conditional branch
//   br_funct3  out 3     branch condition
//   illegal    out 1     undecodable instruction
// Illegal instructions are turned into a NOP (ADD 0+0, no writeback, no branch).
module alu_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic [2:0]      br_funct3,
    output logic            illegal
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] shamt_s;

    logic [XLEN-1:0] dec_a_s;
    logic [XLEN-1:0] dec_b_s;
    alu_op_e         dec_op_s;
    logic            dec_wr_s;
    logic            dec_br_s;
    logic            dec_ill_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    // Signed casts give sign extension to XLEN for any XLEN >= 32.
    assign imm_i_s  = XLEN'($signed(instr[31:20]));
    assign imm_s_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u_s  = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt_s  = XLEN'(instr[24:20]);

    // Raw decode per opcode; the NOP override for illegal encodings is applied below.
    always_comb begin
        dec_a_s   = '0;
        dec_b_s   = '0;
        dec_op_s  = ALU_ADD;
        dec_wr_s  = 1'b0;
        dec_br_s  = 1'b0;
        dec_ill_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                dec_a_s  = rs1_data;
                dec_b_s  = rs2_data;
                dec_wr_s = 1'b1;
                case (funct3_s)
                    3'b000:  dec_op_s = (funct7_s == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_op_s = ALU_SLL;
                    3'b010:  dec_op_s = ALU_SLT;
                    3'b011:  dec_op_s = ALU_SLTU;
                    3'b100:  dec_op_s = ALU_XOR;
                    3'b101:  dec_op_s = (funct7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_op_s = ALU_OR;
                    3'b111:  dec_op_s = ALU_AND;
                    default: dec_op_s = ALU_ADD;
                endcase
            end
            OP_IMM: begin
                dec_a_s  = rs1_data;
                dec_b_s  = imm_i_s;
                dec_wr_s = 1'b1;
                case (funct3_s)
                    3'b000:  dec_op_s = ALU_ADD;
                    3'b010:  dec_op_s = ALU_SLT;
                    3'b011:  dec_op_s = ALU_SLTU;
                    3'b100:  dec_op_s = ALU_XOR;
                    3'b110:  dec_op_s = ALU_OR;
                    3'b111:  dec_op_s = ALU_AND;
                    3'b001: begin
                        dec_op_s  = ALU_SLL;
                        dec_b_s   = shamt_s;
                        dec_ill_s = !shift_funct7_ok(funct7_s, 1'b0);
                    end
                    3'b101: begin
                        dec_op_s  = instr[30] ? ALU_SRA : ALU_SRL;
                        dec_b_s   = shamt_s;
                        dec_ill_s = !shift_funct7_ok(funct7_s, 1'b1);
                    end
                    default: dec_op_s = ALU_ADD;
                endcase
            end
            OP_LOAD: begin
                dec_a_s  = rs1_data;
                dec_b_s  = imm_i_s;
                dec_wr_s = 1'b1;
            end
            OP_STORE: begin
                dec_a_s  = rs1_data;
                dec_b_s  = imm_s_s;
            end
            OP_LUI: begin
                dec_b_s  = imm_u_s;
                dec_wr_s = 1'b1;
            end
            OP_AUIPC: begin
                dec_a_s  = pc;
                dec_b_s  = imm_u_s;
                dec_wr_s = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                // Link value pc+4; target computation lives elsewhere.
                dec_a_s  = pc;
                dec_b_s  = XLEN'(32'd4);
                dec_wr_s = 1'b1;
            end
            OP_BRANCH: begin
                dec_a_s  = rs1_data;
                dec_b_s  = rs2_data;
                dec_br_s = 1'b1;
                case (funct3_s)
                    3'b000, 3'b001: dec_op_s = ALU_SUB;
                    3'b100, 3'b101: dec_op_s = ALU_SLT;
                    3'b110, 3'b111: dec_op_s = ALU_SLTU;
                    default:        dec_ill_s = 1'b1;
                endcase
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    assign a         = dec_ill_s ? '0 : dec_a_s;
    assign b         = dec_ill_s ? '0 : dec_b_s;
    assign alu_ctrl  = dec_ill_s ? ALU_ADD : dec_op_s;
    assign rd        = instr[11:7];
    assign reg_write = dec_wr_s && !dec_ill_s && (instr[11:7] != 5'd0);
    assign is_branch = dec_br_s && !dec_ill_s;
    assign br_funct3 = (dec_br_s && !dec_ill_s) ? funct3_s : 3'b000;
    assign illegal   = dec_ill_s;

endmodule

// File: rtl/alu_issue_stage.sv
// Module: alu_issue_stage
// Decode/execute boundary register feeding the EX-stage ALU.
// Decodes each RV32I instruction (alu_decoder) and registers the result behind
// a valid/ready handshake; flush from the hazard unit squashes the held and
// incoming instruction.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//   instr, pc             instruction word and its address
//   rs1_data, rs2_data    register-file operands
//   flush                 squash (branch redirect)
//   out_valid / out_ready downstream handshake to EX
//   a, b, alu_ctrl        ALU operands and operation
//   rd, reg_write         writeback destination / enable
//   is_branch, br_funct3  branch flag and condition for EX
//   pc_out                pc of the issued instruction (RESET_PC in reset)
//   illegal               undecodable instruction flag
// Configuration macro: ALU_ILLEGAL_TRAP_EN -- when defined, illegal is registered
// with the instruction; otherwise it is tied 0 and illegal instructions issue as NOPs.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic [2:0]      br_funct3,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    logic [XLEN-1:0] dec_a_s;
    logic [XLEN-1:0] dec_b_s;
    logic [3:0]      dec_ctrl_s;
    logic [4:0]      dec_rd_s;
    logic            dec_wr_s;
    logic            dec_br_s;
    logic [2:0]      dec_f3_s;
    logic            dec_ill_s;
    logic            load_s;

    logic            out_valid_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [3:0]      alu_ctrl_r;
    logic [4:0]      rd_r;
    logic            reg_write_r;
    logic            is_branch_r;
    logic [2:0]      br_funct3_r;
    logic [XLEN-1:0] pc_out_r;

    alu_decoder #(.XLEN(XLEN)) u_dec (
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .a         (dec_a_s),
        .b         (dec_b_s),
        .alu_ctrl  (dec_ctrl_s),
        .rd        (dec_rd_s),
        .reg_write (dec_wr_s),
        .is_branch (dec_br_s),
        .br_funct3 (dec_f3_s),
        .illegal   (dec_ill_s)
    );

    // The register may take a new entry when empty or when EX drains it this cycle.
    assign load_s   = !out_valid_r || out_ready;
    assign in_ready = load_s;

    // Handshake/output register; flush only kills validity, data may hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            alu_ctrl_r  <= 4'b0000;
            rd_r        <= 5'd0;
            reg_write_r <= 1'b0;
            is_branch_r <= 1'b0;
            br_funct3_r <= 3'b000;
            pc_out_r    <= RESET_PC;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                a_r         <= dec_a_s;
                b_r         <= dec_b_s;
                alu_ctrl_r  <= dec_ctrl_s;
                rd_r        <= dec_rd_s;
                reg_write_r <= dec_wr_s;
                is_branch_r <= dec_br_s;
                br_funct3_r <= dec_f3_s;
                pc_out_r    <= pc;
            end
        end
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Trap flag travels with the instruction it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (flush) begin
            illegal_r <= 1'b0;
        end else if (load_s && in_valid) begin
            illegal_r <= dec_ill_s;
        end
    end

    assign illegal = illegal_r;
`else
    logic unused_ill_s;
    assign unused_ill_s = dec_ill_s;
    assign illegal      = 1'b0;
`endif

    assign out_valid = out_valid_r;
    assign a         = a_r;
    assign b         = b_r;
    assign alu_ctrl  = alu_ctrl_r;
    assign rd        = rd_r;
    assign reg_write = reg_write_r;
    assign is_branch = is_branch_r;
    assign br_funct3 = br_funct3_r;
    assign pc_out    = pc_out_r;

endmodule
